// File: rtl/vending_brewer_if.sv
// Front-panel bundle for vending_brewer: coin/button levels in, credit/change and valve drives out.
interface vending_brewer_if #(
    parameter int NUM_TYPES = 4,
    parameter int CREDIT_W  = 8
);
    localparam int TYPE_W = $clog2(NUM_TYPES);

    logic                coin_100;
    logic                coin_500;
    logic [TYPE_W-1:0]   coffee_type;
    logic                confirm;
    logic                cancel;
    logic [CREDIT_W-1:0] credit;
    logic [CREDIT_W-1:0] change;
    logic                water;
    logic                coffee;
    logic                sugar;
    logic                milk;
    logic                chocolate;
    logic                busy;
    logic                finished;
    logic                reject;
    logic                insufficient;

    modport master (
        output coin_100, coin_500, coffee_type, confirm, cancel,
        input  credit, change, water, coffee, sugar, milk, chocolate,
        input  busy, finished, reject, insufficient
    );

    modport slave (
        input  coin_100, coin_500, coffee_type, confirm, cancel,
        output credit, change, water, coffee, sugar, milk, chocolate,
        output busy, finished, reject, insufficient
    );
endinterface

// File: rtl/vending_brewer.sv
// Coin-credit drink vending controller with timed valve sequencing and change return.
// Optional cancel/refund path is built only when VENDING_REFUND_EN is defined.
module vending_brewer #(
    parameter int                            NUM_TYPES   = 4,
    parameter int                            CREDIT_W    = 8,
    parameter logic [NUM_TYPES*CREDIT_W-1:0] PRICES      = {8'd5, 8'd4, 8'd3, 8'd2},
    parameter logic [NUM_TYPES*4-1:0]        RECIPES     = {4'b1111, 4'b1011, 4'b0011, 4'b0001},
    parameter int                            STEP_CYCLES = 16
) (
    input logic             clock,
    input logic             reset,
    vending_brewer_if.slave bus
);
    localparam int TYPE_W = $clog2(NUM_TYPES);
    localparam int CNT_W  = $clog2(STEP_CYCLES + 1);
    localparam int SUM_W  = CREDIT_W + 3;

    typedef enum logic [1:0] {IDLE, DISPENSE, DONE} state_t;

    state_t              state;
    logic [CREDIT_W-1:0] credit;
    logic [CREDIT_W-1:0] change;
    logic [4:0]          mask;
    logic [4:0]          valves;
    logic [2:0]          phase;
    logic [CNT_W-1:0]    step_cnt;
    logic                busy;
    logic                finished;
    logic                reject;
    logic                insufficient;
    logic                prev_100;
    logic                prev_500;
    logic                prev_confirm;
    logic                edge_100;
    logic                edge_500;
    logic                edge_confirm;
    logic                coin_any;
    logic                coin_ovf;
    logic [SUM_W-1:0]    coin_sum;
    logic [CREDIT_W-1:0] credit_eff;
    logic [CREDIT_W-1:0] price_sel;
    logic [3:0]          recipe_sel;
    logic                type_ok;
    logic [2:0]          phase_nxt;
    logic                do_refund;

    // Phase 5 means "no further phase": the dispense is over.
    function automatic logic [2:0] next_phase(input logic [4:0] m, input logic [2:0] cur);
        logic [2:0] nxt;
        nxt = 3'd5;
        for (int i = 4; i >= 0; i--) begin
            if (m[i] && (3'(i) > cur)) nxt = 3'(i);
        end
        return nxt;
    endfunction

    always_comb begin
        edge_100     = bus.coin_100 & ~prev_100;
        edge_500     = bus.coin_500 & ~prev_500;
        edge_confirm = bus.confirm & ~prev_confirm;
        coin_any     = edge_100 | edge_500;
        coin_sum     = SUM_W'(credit) + (edge_100 ? SUM_W'(1) : '0) + (edge_500 ? SUM_W'(5) : '0);
        coin_ovf     = coin_sum > SUM_W'({CREDIT_W{1'b1}});
        // Coins land first so a same-cycle confirm or cancel sees the new credit.
        credit_eff   = (coin_any && !coin_ovf) ? coin_sum[CREDIT_W-1:0] : credit;
        price_sel    = '0;
        recipe_sel   = '0;
        type_ok      = 1'b0;
        for (int i = 0; i < NUM_TYPES; i++) begin
            if (bus.coffee_type == TYPE_W'(i)) begin
                price_sel  = PRICES[i*CREDIT_W +: CREDIT_W];
                recipe_sel = RECIPES[i*4 +: 4];
                type_ok    = 1'b1;
            end
        end
        phase_nxt = next_phase(mask, phase);
    end

`ifdef VENDING_REFUND_EN
    logic prev_cancel;

    always_ff @(posedge clock) prev_cancel <= bus.cancel;

    assign do_refund = bus.cancel && !prev_cancel && (credit_eff != '0);
`else
    logic unused_cancel;

    assign unused_cancel = bus.cancel;
    assign do_refund     = 1'b0;
`endif

    always_ff @(posedge clock) begin
        // Edge history tracks the inputs even in reset, so held levels never count as edges.
        prev_100     <= bus.coin_100;
        prev_500     <= bus.coin_500;
        prev_confirm <= bus.confirm;
        if (reset) begin
            state        <= IDLE;
            credit       <= '0;
            change       <= '0;
            mask         <= '0;
            valves       <= '0;
            phase        <= '0;
            step_cnt     <= '0;
            busy         <= 1'b0;
            finished     <= 1'b0;
            reject       <= 1'b0;
            insufficient <= 1'b0;
        end else begin
            finished     <= 1'b0;
            reject       <= 1'b0;
            insufficient <= 1'b0;
            case (state)
                IDLE: begin
                    if (coin_any) begin
                        if (coin_ovf) begin
                            reject <= 1'b1;
                        end else begin
                            credit <= coin_sum[CREDIT_W-1:0];
                            change <= '0;
                        end
                    end
                    if (do_refund) begin
                        change   <= credit_eff;
                        credit   <= '0;
                        busy     <= 1'b1;
                        finished <= 1'b1;
                        state    <= DONE;
                    end else if (edge_confirm) begin
                        if (!type_ok || (credit_eff < price_sel)) begin
                            insufficient <= 1'b1;
                        end else begin
                            change   <= credit_eff - price_sel;
                            credit   <= '0;
                            mask     <= {recipe_sel, 1'b1};
                            phase    <= '0;
                            step_cnt <= '0;
                            valves   <= 5'b00001;
                            busy     <= 1'b1;
                            state    <= DISPENSE;
                        end
                    end
                end
                DISPENSE: begin
                    if (coin_any) reject <= 1'b1;
                    if (step_cnt == CNT_W'(STEP_CYCLES - 1)) begin
                        step_cnt <= '0;
                        if (phase_nxt == 3'd5) begin
                            valves   <= '0;
                            finished <= 1'b1;
                            state    <= DONE;
                        end else begin
                            phase  <= phase_nxt;
                            valves <= 5'(5'b00001 << phase_nxt);
                        end
                    end else begin
                        step_cnt <= step_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (coin_any) reject <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.credit       = credit;
    assign bus.change       = change;
    assign bus.water        = valves[0];
    assign bus.coffee       = valves[1];
    assign bus.sugar        = valves[2];
    assign bus.milk         = valves[3];
    assign bus.chocolate    = valves[4];
    assign bus.busy         = busy;
    assign bus.finished     = finished;
    assign bus.reject       = reject;
    assign bus.insufficient = insufficient;
endmodule
